// File: rtl/leaf_dispatch_rr.sv
// Round-robin dispatch: input FIFO, one holding register, one-hot offer to NUM_LEAVES leaves.
// Optional stall-timeout leaf skipping is enabled with `define LEAF_DISPATCH_SKIP_EN.
module leaf_dispatch_rr #(
  parameter int DATA_W     = 8,
  parameter int NUM_LEAVES = 5,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic [NUM_LEAVES-1:0]      out_valid,
  input  logic [NUM_LEAVES-1:0]      out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic [15:0]                sent_count,
  output logic [7:0]                 skip_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(NUM_LEAVES);

  if (NUM_LEAVES < 2 || NUM_LEAVES > 16) begin : g_bad_leaves
    $error("leaf_dispatch_rr: NUM_LEAVES must be 2..16");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("leaf_dispatch_rr: DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("leaf_dispatch_rr: TIMEOUT must be 1..255");
  end

  typedef enum logic {IDLE, OFFER} state_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count_q;
  logic              full, empty, push, pop;

  state_t            state_q, state_d;
  logic [PW-1:0]     rr_ptr_q, rr_next;
  logic [DATA_W-1:0] hold_q;
  logic [15:0]       sent_q;
  logic              hs, advance, skip;

  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);
  // No pass-through when full, even if the head leaves this cycle.
  assign in_ready   = !rst && !full;
  assign push       = in_valid && in_ready;
  assign fifo_count = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  assign hs      = (state_q == OFFER) && out_ready[rr_ptr_q];
  assign rr_next = (rr_ptr_q == PW'(NUM_LEAVES - 1)) ? '0 : rr_ptr_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    advance   = 1'b0;
    out_valid = '0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = OFFER;
        end
      end
      OFFER: begin
        out_valid[rr_ptr_q] = 1'b1;
        if (hs) begin
          advance = 1'b1;
          if (!empty) pop = 1'b1;
          else        state_d = IDLE;
        end else if (skip) begin
          advance = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      hold_q   <= '0;
      sent_q   <= '0;
    end else begin
      state_q <= state_d;
      if (advance) rr_ptr_q <= rr_next;
      if (pop)     hold_q   <= mem[rd_ptr];
      if (hs)      sent_q   <= sent_q + 1'b1;
    end
  end

  assign out_data   = hold_q;
  assign sent_count = sent_q;

`ifdef LEAF_DISPATCH_SKIP_EN
  logic [7:0] stall_q;
  logic [7:0] skip_q;

  // Skip fires on the TIMEOUT-th consecutive stalled cycle; a handshake always wins.
  assign skip = (state_q == OFFER) && !out_ready[rr_ptr_q] && (stall_q == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      skip_q  <= '0;
    end else begin
      if (state_q != OFFER || hs || skip) stall_q <= '0;
      else                                stall_q <= stall_q + 1'b1;
      if (skip && skip_q != 8'hFF) skip_q <= skip_q + 1'b1;
    end
  end

  assign skip_count = skip_q;
`else
  assign skip       = 1'b0;
  assign skip_count = '0;
`endif

endmodule

// File: tb/tb_leaf_dispatch_rr.sv
// Self-checking bench for leaf_dispatch_rr: vector table, directed corner sequences, random vs queue model.
module tb_leaf_dispatch_rr;
  localparam int DATA_W  = 8;
  localparam int NL      = 5;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [NL-1:0]     out_valid;
  logic [NL-1:0]     out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CW-1:0]     fifo_count;
  logic [15:0]       sent_count;
  logic [7:0]        skip_count;

  leaf_dispatch_rr #(.DATA_W(DATA_W), .NUM_LEAVES(NL), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .fifo_count(fifo_count), .sent_count(sent_count), .skip_count(skip_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    tick();
    rst      = 1'b0;
  endtask

  typedef struct {
    logic          iv;
    logic [7:0]    id;
    logic [NL-1:0] ordy;
    logic [NL-1:0] ov;
    logic [7:0]    od;
    int            cnt;
    int            sent;
  } vec_t;

  vec_t tbl[10];

  // Reference model state
  logic [7:0] mq[$];
  bit         m_have;
  logic [7:0] m_hold;
  int         m_tgt, m_sent, m_skip, m_stall;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, cnt;
    bit found;
    logic [NL-1:0] ev;
    bit exp_ir, hs;

    tbl[0] = '{1'b1, 8'h10, 5'h1f, 5'h00, 8'h00, 0, 0};
    tbl[1] = '{1'b1, 8'h11, 5'h1f, 5'h00, 8'h00, 1, 0};
    tbl[2] = '{1'b1, 8'h12, 5'h1f, 5'h01, 8'h10, 1, 0};
    tbl[3] = '{1'b1, 8'h13, 5'h1f, 5'h02, 8'h11, 1, 1};
    tbl[4] = '{1'b1, 8'h14, 5'h1f, 5'h04, 8'h12, 1, 2};
    tbl[5] = '{1'b1, 8'h15, 5'h1f, 5'h08, 8'h13, 1, 3};
    tbl[6] = '{1'b1, 8'h16, 5'h1f, 5'h10, 8'h14, 1, 4};
    tbl[7] = '{1'b0, 8'h00, 5'h1f, 5'h01, 8'h15, 1, 5};
    tbl[8] = '{1'b0, 8'h00, 5'h1f, 5'h02, 8'h16, 0, 6};
    tbl[9] = '{1'b0, 8'h00, 5'h1f, 5'h00, 8'h00, 0, 7};

    rst = 1'b1; in_valid = 1'b1; in_data = 8'h77; out_ready = '0;

    // Reset held three cycles with in_valid high
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_fifo_count", fifo_count, 0);
      check("rst_sent", sent_count, 0);
      tick();
    end
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("rst_release_in_ready", in_ready, 1);
    check("rst_skip", skip_count, 0);
    tick();

    // Rotation table
    do_reset();
    for (int i = 0; i < 10; i++) begin
      in_valid  = tbl[i].iv;
      in_data   = tbl[i].id;
      out_ready = tbl[i].ordy;
      @(negedge clk);
      check($sformatf("rot%0d_out_valid", i), out_valid, tbl[i].ov);
      if (tbl[i].ov != '0) check($sformatf("rot%0d_out_data", i), out_data, tbl[i].od);
      check($sformatf("rot%0d_fifo_count", i), fifo_count, tbl[i].cnt);
      check($sformatf("rot%0d_sent", i), sent_count, tbl[i].sent);
      check($sformatf("rot%0d_in_ready", i), in_ready, 1);
      tick();
    end

    // Backpressure: capacity is DEPTH + 1, no pass-through when full
    do_reset();
    out_ready = '0; in_valid = 1'b1; acc = 0; found = 0;
    for (int n = 0; n < 20; n++) begin
      in_data = 8'(8'h60 + n);
      @(negedge clk);
      if (!in_ready) begin found = 1; break; end
      acc++;
      tick();
    end
    check("bp_full_seen", found, 1);
    check("bp_accepted", acc, 5);
    check("bp_fifo_count", fifo_count, 4);
    check("bp_out_valid", out_valid, 5'b00001);
    tick();
    out_ready = 5'b00001;
    @(negedge clk);
    check("bp_full_during_pop", in_ready, 0);
    tick();
    out_ready = '0;
    @(negedge clk);
    check("bp_in_ready_back", in_ready, 1);
    check("bp_fifo_after", fifo_count, 3);
    check("bp_next_target", out_valid, 5'b00010);
    check("bp_sent", sent_count, 1);
    in_valid = 1'b0;
    tick();

    // Hold stability and one-cycle latency
    do_reset();
    out_ready = '0; in_valid = 1'b1; in_data = 8'hA5;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_idle_out_valid", out_valid, 0);
    check("lat_fifo_count", fifo_count, 1);
    tick();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("hold%0d_out_valid", i), out_valid, 5'b00001);
      check($sformatf("hold%0d_out_data", i), out_data, 8'hA5);
      tick();
    end
    out_ready = 5'b00001;
    @(negedge clk);
    check("hold_hs_out_valid", out_valid, 5'b00001);
    check("hold_hs_sent_before", sent_count, 0);
    tick();
    out_ready = '0;
    @(negedge clk);
    check("hold_after_out_valid", out_valid, 0);
    check("hold_after_sent", sent_count, 1);
    tick();

`ifdef LEAF_DISPATCH_SKIP_EN
    // Leaf 2 never ready: item re-offered to leaf 3 after TIMEOUT stalls
    do_reset();
    out_ready = 5'b11011;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = 8'(8'h20 + k);
      tick();
    end
    in_valid = 1'b0;
    found = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (out_valid == 5'b00100) begin found = 1; break; end
      tick();
    end
    check("skip_leaf2_seen", found, 1);
    check("skip_leaf2_data", out_data, 8'h22);
    cnt = 0;
    while (out_valid == 5'b00100 && cnt < 20) begin
      cnt++;
      tick();
      @(negedge clk);
    end
    check("skip_stall_cycles", cnt, TIMEOUT);
    check("skip_new_target", out_valid, 5'b01000);
    check("skip_same_data", out_data, 8'h22);
    check("skip_count", skip_count, 1);
    tick();
    @(negedge clk);
    check("skip_next_target", out_valid, 5'b10000);
    check("skip_next_data", out_data, 8'h23);
    tick();
`endif

    // Mid-operation reset
    do_reset();
    out_ready = '1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 8'(8'h30 + k);
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    check("mid_sent_pre", sent_count, 3);
    tick();
    out_ready = '0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = 8'(8'h40 + k);
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_target3", out_valid, 5'b01000);
    check("mid_queued", fifo_count, 3);
    check("mid_data", out_data, 8'h40);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_fifo", fifo_count, 0);
    check("mid_rst_sent", sent_count, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_skip", skip_count, 0);
    tick();
    in_valid = 1'b1; in_data = 8'h55;
    tick();
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    check("mid_next_leaf0", out_valid, 5'b00001);
    check("mid_next_data", out_data, 8'h55);
    tick();

    // Random traffic against a queue-level model
    do_reset();
    mq.delete();
    m_have = 0; m_hold = '0; m_tgt = 0; m_sent = 0; m_skip = 0; m_stall = 0;
    for (int c = 0; c < 600; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      out_ready = NL'($urandom);
      @(negedge clk);
      exp_ir = (mq.size() < DEPTH);
      ev = m_have ? (NL'(1) << m_tgt) : '0;
      check("rnd_in_ready", in_ready, exp_ir);
      check("rnd_fifo_count", fifo_count, mq.size());
      check("rnd_out_valid", out_valid, ev);
      if (m_have) check("rnd_out_data", out_data, m_hold);
      check("rnd_sent", sent_count, m_sent & 16'hFFFF);
      check("rnd_skip", skip_count, m_skip);

      hs = m_have && out_ready[m_tgt];
      if (hs) begin
        m_sent++;
        m_tgt   = (m_tgt + 1) % NL;
        m_stall = 0;
      end else if (m_have) begin
`ifdef LEAF_DISPATCH_SKIP_EN
        m_stall++;
        if (m_stall == TIMEOUT) begin
          m_tgt   = (m_tgt + 1) % NL;
          m_stall = 0;
          if (m_skip < 255) m_skip++;
        end
`endif
      end
      if (!m_have || hs) begin
        if (mq.size() > 0) begin
          m_hold  = mq.pop_front();
          m_have  = 1;
          m_stall = 0;
        end else begin
          m_have = 0;
        end
      end
      if (in_valid && exp_ir) mq.push_back(in_data);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
